// File: rtl/fpnew_noncomp_result_buf.sv
// Result buffer behind the non-computational FP unit: formats raw results into
// FLEN-wide writeback words, queues them in a small FIFO and accumulates sticky fflags.
module fpnew_noncomp_result_buf #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FLEN     = 64,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned TagWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WIDTH-1:0]    result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  logic [9:0]          class_mask_i,
  input  logic                is_class_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [FLEN-1:0]     result_o,
  output logic [4:0]          status_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic                busy_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [FLEN-1:0]     word;
    logic [4:0]          status;
    logic [TagWidth-1:0] tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             in_entry;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [4:0]         fflags_q, fflags_d;
  logic               push, pop;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Writeback formatting: class mask zero-extended, otherwise fill upper bits
  // with the extension bit (NaN-boxing or integer sign/zero extension).
  always_comb begin
    in_entry     = '0;
    in_entry.tag = tag_i;
    if (is_class_i) begin
      in_entry.word = FLEN'(class_mask_i);
    end else begin
      in_entry.word              = {FLEN{extension_bit_i}};
      in_entry.word[WIDTH-1:0]   = result_i;
      in_entry.status            = status_i;
    end
  end

  assign push = in_valid_i & in_ready_q & ~flush_i;
  assign pop  = out_valid_q & out_ready_i & ~flush_i;

  // Pointer, occupancy and sticky-flag next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (pop) fflags_d = fflags_d | mem_q[rd_ptr_q].status;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = inc_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    in_ready_d  = (cnt_d != CntW'(DEPTH));
    out_valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fflags_q    <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fflags_q    <= fflags_d;
    end
  end

  // Entry storage, cleared on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign result_o    = mem_q[rd_ptr_q].word;
  assign status_o    = mem_q[rd_ptr_q].status;
  assign tag_o       = mem_q[rd_ptr_q].tag;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = out_valid_q;
  assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_fpnew_noncomp_result_buf.sv
// Self-checking bench for fpnew_noncomp_result_buf: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_fpnew_noncomp_result_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result_i;
  logic [4:0]  status_i;
  logic        extension_bit_i;
  logic [9:0]  class_mask_i;
  logic        is_class_i;
  logic [7:0]  tag_i;
  logic        in_valid_i, in_ready_o, flush_i;
  logic [63:0] result_o;
  logic [4:0]  status_o;
  logic [7:0]  tag_o;
  logic        out_valid_o, out_ready_i;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i, busy_o;

  int checks = 0;
  int errors = 0;

  fpnew_noncomp_result_buf #(.WIDTH(32), .FLEN(64), .DEPTH(2), .TagWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .result_i(result_i), .status_i(status_i),
    .extension_bit_i(extension_bit_i), .class_mask_i(class_mask_i),
    .is_class_i(is_class_i), .tag_i(tag_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .result_o(result_o),
    .status_o(status_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ext;
    logic [9:0]  mask;
    logic        is_class;
    logic [4:0]  st;
    logic [7:0]  tag;
    logic [63:0] exp_word;
    logic [4:0]  exp_st;
  } vec_t;

  typedef struct {
    logic [63:0] word;
    logic [4:0]  st;
    logic [7:0]  tag;
  } ment_t;

  vec_t  vecs [5];
  ment_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid_i = 0; out_ready_i = 0; flush_i = 0; fflags_clr_i = 0;
    result_i = '0; status_i = '0; extension_bit_i = 0; class_mask_i = '0;
    is_class_i = 0; tag_i = '0;
  endtask

  task automatic set_in(input logic [31:0] r, input logic e, input logic [9:0] m,
                        input logic c, input logic [4:0] s, input logic [7:0] t);
    result_i = r; extension_bit_i = e; class_mask_i = m; is_class_i = c;
    status_i = s; tag_i = t;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #7;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_out_valid"}, 64'(out_valid_o), 64'd0);
    chk({pfx, "_in_ready"},  64'(in_ready_o),  64'd1);
    chk({pfx, "_busy"},      64'(busy_o),      64'd0);
    chk({pfx, "_result"},    result_o,         64'd0);
    chk({pfx, "_status"},    64'(status_o),    64'd0);
    chk({pfx, "_tag"},       64'(tag_o),       64'd0);
    chk({pfx, "_fflags"},    64'(fflags_o),    64'd0);
  endtask

  initial begin
    logic [4:0]  exp_ff;
    logic [63:0] held;
    logic        push, pop;
    ment_t       e;

    vecs[0] = '{32'h3F800000, 1'b1, 10'h000, 1'b0, 5'h00, 8'h05, 64'hFFFFFFFF_3F800000, 5'h00};
    vecs[1] = '{32'h12345678, 1'b1, 10'h040, 1'b1, 5'h10, 8'h06, 64'h0000000000000040, 5'h00};
    vecs[2] = '{32'h00000001, 1'b0, 10'h000, 1'b0, 5'h00, 8'h07, 64'h0000000000000001, 5'h00};
    vecs[3] = '{32'h7FC00000, 1'b0, 10'h000, 1'b0, 5'h10, 8'h08, 64'h000000007FC00000, 5'h10};
    vecs[4] = '{32'hDEADBEEF, 1'b0, 10'h200, 1'b1, 5'h01, 8'h09, 64'h0000000000000200, 5'h00};

    do_reset();
    chk_reset_outputs("reset");

    // Single push/pop per vector
    exp_ff = '0;
    for (int i = 0; i < 5; i++) begin
      set_in(vecs[i].res, vecs[i].ext, vecs[i].mask, vecs[i].is_class, vecs[i].st, vecs[i].tag);
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      chk($sformatf("vec%0d_valid", i),  64'(out_valid_o), 64'd1);
      chk($sformatf("vec%0d_result", i), result_o, vecs[i].exp_word);
      chk($sformatf("vec%0d_status", i), 64'(status_o), 64'(vecs[i].exp_st));
      chk($sformatf("vec%0d_tag", i),    64'(tag_o), 64'(vecs[i].tag));
      out_ready_i = 1;
      tick();
      out_ready_i = 0;
      exp_ff |= vecs[i].exp_st;
      chk($sformatf("vec%0d_empty", i),  64'(out_valid_o), 64'd0);
      chk($sformatf("vec%0d_fflags", i), 64'(fflags_o), 64'(exp_ff));
    end
    fflags_clr_i = 1;
    tick();
    fflags_clr_i = 0;
    chk("fflags_clear", 64'(fflags_o), 64'd0);

    // Fill to full with downstream stalled; third push rejected
    out_ready_i = 0;
    in_valid_i = 1;
    for (int t = 1; t <= 3; t++) begin
      set_in(32'(t) * 32'h111, 1'b0, '0, 1'b0, 5'h00, 8'(t));
      tick();
      if (t == 1) chk("full_ready1", 64'(in_ready_o), 64'd1);
      if (t == 2) begin
        chk("full_ready2", 64'(in_ready_o), 64'd0);
        held = result_o;
      end
    end
    in_valid_i = 0;
    chk("full_stable_res", result_o, held);
    chk("full_head_tag", 64'(tag_o), 64'd1);
    chk("full_ready3", 64'(in_ready_o), 64'd0);
    out_ready_i = 1;
    tick();
    chk("full_pop_tag2", 64'(tag_o), 64'd2);
    chk("full_pop_res2", result_o, 64'h222);
    tick();
    out_ready_i = 0;
    chk("full_drained", 64'(out_valid_o), 64'd0);

    // Back-to-back push+pop with one entry held
    set_in(32'hA0, 1'b0, '0, 1'b0, 5'h0, 8'd10);
    in_valid_i = 1;
    tick();
    out_ready_i = 1;
    for (int k = 11; k <= 15; k++) begin
      set_in(32'hA0 + 32'(k - 10), 1'b0, '0, 1'b0, 5'h0, 8'(k));
      tick();
      chk($sformatf("b2b_tag%0d", k), 64'(tag_o), 64'(k));
      chk($sformatf("b2b_res%0d", k), result_o, 64'hA0 + 64'(k - 10));
      chk($sformatf("b2b_busy%0d", k), 64'(busy_o), 64'd1);
    end
    in_valid_i = 0;
    tick();
    out_ready_i = 0;
    chk("b2b_empty", 64'(out_valid_o), 64'd0);

    // Sticky flags and clear coinciding with a pop
    in_valid_i = 1;
    set_in(32'h1, 1'b0, '0, 1'b0, 5'h10, 8'd20); tick();
    set_in(32'h2, 1'b0, '0, 1'b0, 5'h01, 8'd21); tick();
    in_valid_i = 0;
    out_ready_i = 1;
    tick();
    chk("ff_after_10", 64'(fflags_o), 64'h10);
    in_valid_i = 1;
    set_in(32'h3, 1'b0, '0, 1'b0, 5'h02, 8'd22);
    tick();
    in_valid_i = 0;
    chk("ff_after_01", 64'(fflags_o), 64'h11);
    fflags_clr_i = 1;
    tick();
    fflags_clr_i = 0;
    out_ready_i = 0;
    chk("ff_clr_pop", 64'(fflags_o), 64'h02);

    // Flush with concurrent push
    in_valid_i = 1;
    set_in(32'h4, 1'b0, '0, 1'b0, 5'h04, 8'd30); tick();
    set_in(32'h5, 1'b0, '0, 1'b0, 5'h08, 8'd31); tick();
    flush_i = 1;
    out_ready_i = 1;
    tick();
    flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_busy",  64'(busy_o), 64'd0);
    chk("flush_ready", 64'(in_ready_o), 64'd1);
    chk("flush_ff",    64'(fflags_o), 64'h02);
    tick();
    chk("flush_stays_empty", 64'(out_valid_o), 64'd0);

    // Asynchronous reset while holding entries
    in_valid_i = 1;
    set_in(32'h6, 1'b1, '0, 1'b0, 5'h1F, 8'd40); tick();
    set_in(32'h7, 1'b1, '0, 1'b0, 5'h1F, 8'd41); tick();
    in_valid_i = 0;
    #2;
    rst = 1;
    #1;
    chk_reset_outputs("async_rst");
    idle();
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Randomized run against the queue model
    q.delete();
    exp_ff = '0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", 64'(out_valid_o), 64'(q.size() != 0));
      chk("rnd_ready", 64'(in_ready_o), 64'(q.size() != 2));
      chk("rnd_busy",  64'(busy_o), 64'(q.size() != 0));
      chk("rnd_ff",    64'(fflags_o), 64'(exp_ff));
      if (q.size() != 0) begin
        chk("rnd_result", result_o, q[0].word);
        chk("rnd_status", 64'(status_o), 64'(q[0].st));
        chk("rnd_tag",    64'(tag_o), 64'(q[0].tag));
      end
      set_in($urandom, 1'($urandom), 10'(1 << $urandom_range(9, 0)),
             ($urandom_range(3, 0) == 0), 5'($urandom), 8'($urandom));
      in_valid_i   = 1'($urandom);
      out_ready_i  = ($urandom_range(3, 0) != 0);
      flush_i      = ($urandom_range(15, 0) == 0);
      fflags_clr_i = ($urandom_range(7, 0) == 0);

      push = in_valid_i && (q.size() != 2) && !flush_i;
      pop  = out_ready_i && (q.size() != 0) && !flush_i;
      e.tag  = tag_i;
      e.word = is_class_i ? {54'd0, class_mask_i} : {{32{extension_bit_i}}, result_i};
      e.st   = is_class_i ? 5'h00 : status_i;
      exp_ff = (fflags_clr_i ? 5'h00 : exp_ff) | (pop ? q[0].st : 5'h00);
      if (flush_i) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_noncomp_result_buf.md
Name: fpnew_noncomp_result_buf

Overview:
- Downstream stage of the non-computational FP unit (sign-injection, min/max, compare, classify).
- Consumes that unit's raw WIDTH-bit result, status, extension bit, class mask and is-class flag, and formats them into an FLEN-wide writeback word.
  - Float results are NaN-boxed; integer-register results are extended.
  - Classify results are converted to the class mask.
- Buffers results in a DEPTH-entry FIFO with valid/ready handshakes and accumulates sticky fflags for the CSR.

Parameters:
- WIDTH, 32, width of the source FP format result.
- FLEN, 64, writeback word width; FLEN >= WIDTH and FLEN >= 10.
- DEPTH, 2, FIFO entries; must be >= 1.
- TagWidth, 8, width of the opaque tag carried with each result.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- result_i  in  WIDTH  raw result from the non-comp unit.
- status_i  in  5  flags {NV,DZ,OF,UF,NX}, MSB to LSB.
- extension_bit_i  in  1  fill value for bits FLEN-1:WIDTH.
- class_mask_i  in  10  one-hot class mask: bit0 NEGINF .. bit9 QNAN.
- is_class_i  in  1  result is a classification.
- tag_i  in  TagWidth  tag.
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  upstream ready.
- flush_i  in  1  synchronous flush.
- result_o  out  FLEN  formatted head-entry result.
- status_o  out  5  head-entry flags.
- tag_o  out  TagWidth  head-entry tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream ready.
- fflags_o  out  5  sticky accumulated flags.
- fflags_clr_i  in  1  clear sticky flags.
- busy_o  out  1  any entry held.

Behaviour:
- Single clock. Reset is asynchronous and active-high, on rst_i.
- Reset values:
  - Count, read pointer, write pointer and fflags_o are 0.
  - out_valid_o = 0, in_ready_o = 1 (DEPTH >= 1), busy_o = 0.
  - result_o, status_o and tag_o are 0; entry storage is cleared.
  - Reset mid-operation discards every entry.
- Formatting, combinational on input, stored at push:
  - is_class_i = 1: word = zero-extended class_mask_i; stored status = 0 regardless of status_i.
  - is_class_i = 0: word[WIDTH-1:0] = result_i; word[FLEN-1:WIDTH] = all copies of extension_bit_i (nothing to fill when FLEN == WIDTH); stored status = status_i.
- Push = in_valid_i & in_ready_o & ~flush_i.
- Pop = out_valid_o & out_ready_i & ~flush_i.
- in_ready_o = (count != DEPTH). There is no bypass when full: a simultaneous pop does not make room in the same cycle.
- out_valid_o = (count != 0). result_o, status_o and tag_o show the head entry directly from storage.
- busy_o = (count != 0).
- Latency: a result accepted in cycle N appears on the outputs in cycle N+1 at the earliest. There is no combinational path from in_* to out_*.
- Pointer and count updates:
  - Each pointer increments on its own event and wraps from DEPTH-1 to 0.
  - Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (legal when 0 < count < DEPTH).
- Empty with push: the entry becomes visible the next cycle; no pop is possible that cycle.
- Flush: next cycle count, read pointer and write pointer = 0; a same-cycle push or pop is ignored; fflags_o is not affected.
- Ordering: strict FIFO; the tag travels with its entry.
- Sticky flags: next fflags_o = (fflags_clr_i ? 0 : fflags_o) | (pop ? head status : 0). A clear in the same cycle as a pop keeps the popped flags.
- Output data is held stable while out_valid_o = 1 and out_ready_i = 0.

Test Plan:
1. Reset, then push one entry with WIDTH=32, FLEN=64, result_i=32'h3F800000, extension_bit_i=1, is_class_i=0, tag 8'h5 -> next cycle out_valid_o=1, result_o=64'hFFFFFFFF_3F800000, tag_o=8'h5; pop -> fflags_o stays 0.
2. Push a classify entry with class_mask_i=10'h040 and status_i=5'h10 -> result_o=64'h40, status_o=0. Then push a compare entry with result_i=1, extension_bit_i=0 -> result_o=64'h1.
3. DEPTH=2, out_ready_i=0, three pushes on consecutive cycles -> in_ready_o=0 after the second push; the third is not accepted; outputs stay stable. Release out_ready_i -> entries pop in tag order 1, 2.
4. With count=1, push and pop in the same cycle -> count stays 1; pointers wrap correctly over 5 back-to-back transfers with data and tags in order.
5. Pop entries carrying status 5'h10 and then 5'h01 -> fflags_o=5'h11. Assert fflags_clr_i in the same cycle as a pop of 5'h02 -> fflags_o=5'h02.
6. With 2 entries held, assert flush_i together with in_valid_i -> next cycle out_valid_o=0, busy_o=0, in_ready_o=1, fflags_o unchanged. Assert rst_i asynchronously while entries are held -> all outputs return to reset values immediately.
